// File: rtl/shift_add_mult_if.sv
// shift_add_mult_if: operand/result bus between the multiplier port mux (master) and the shared multiplier (slave)
//   start_i            request pulse, sampled by the multiplier only while idle
//   mult_a_i/mult_b_i  signed operands, Q(DataWidth-FracBits).FracBits
//   value_o/overflow_o saturated result and saturation flag
//   done_o             one-cycle completion pulse
//   valid_o            value_o/overflow_o hold a completed result
//   busy_o             operation in progress
interface shift_add_mult_if #(parameter int DataWidth = 8);
    logic                 start_i;
    logic [DataWidth-1:0] mult_a_i;
    logic [DataWidth-1:0] mult_b_i;
    logic [DataWidth-1:0] value_o;
    logic                 overflow_o;
    logic                 done_o;
    logic                 valid_o;
    logic                 busy_o;
    modport master (output start_i, mult_a_i, mult_b_i, input value_o, overflow_o, done_o, valid_o, busy_o);
    modport slave  (input start_i, mult_a_i, mult_b_i, output value_o, overflow_o, done_o, valid_o, busy_o);
endinterface

// File: rtl/shift_add_mult.sv
// shift_add_mult: shared sequential signed fixed-point radix-2 shift-add multiplier with rescale and saturation
//   clk_i  clock, rst_i synchronous active-high reset
//   bus    shift_add_mult_if.slave: start_i, mult_a_i, mult_b_i in; value_o, overflow_o, done_o, valid_o, busy_o out
module shift_add_mult #(
    parameter int DataWidth = 8,
    parameter int FracBits  = 4
) (
    input logic             clk_i,
    input logic             rst_i,
    shift_add_mult_if.slave bus
);
    localparam int W  = DataWidth;
    localparam int CW = $clog2(DataWidth);
    localparam logic signed [2*W:0] MAX_V = {{(W+2){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

    state_t              state, state_n;
    logic [2*W-1:0]      acc, mcand;
    logic [W-1:0]        mplier, abs_a, abs_b, value, sat;
    logic [CW-1:0]       cnt;
    logic                sign, overflow, done, valid, ovf;
    logic signed [2*W:0] prod, scaled;

    always_comb begin
        // Negating the most negative value wraps to 2^(W-1), which is the correct unsigned magnitude
        abs_a   = bus.mult_a_i[W-1] ? -bus.mult_a_i : bus.mult_a_i;
        abs_b   = bus.mult_b_i[W-1] ? -bus.mult_b_i : bus.mult_b_i;
        prod    = sign ? -{1'b0, acc} : {1'b0, acc};
        scaled  = prod >>> FracBits;
        ovf     = (scaled > MAX_V) || (scaled < MIN_V);
        sat     = scaled > MAX_V ? {1'b0, {(W-1){1'b1}}} :
                  scaled < MIN_V ? {1'b1, {(W-1){1'b0}}} : scaled[W-1:0];
        state_n = state == IDLE ? (bus.start_i ? CALC : IDLE) :
                  state == CALC ? (cnt == CW'(W-1) ? FINISH : CALC) : IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            cnt      <= '0;
            sign     <= 1'b0;
            value    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            done <= state == FINISH;
            if (state == IDLE && bus.start_i) begin
                mcand  <= {{W{1'b0}}, abs_a};
                mplier <= abs_b;
                acc    <= '0;
                cnt    <= '0;
                sign   <= bus.mult_a_i[W-1] ^ bus.mult_b_i[W-1];
                valid  <= 1'b0;
            end
            if (state == CALC) begin
                if (mplier[0]) acc <= acc + mcand;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
            end
            if (state == FINISH) begin
                value    <= sat;
                overflow <= ovf;
                valid    <= 1'b1;
            end
        end
    end

    assign bus.value_o    = value;
    assign bus.overflow_o = overflow;
    assign bus.done_o     = done;
    assign bus.valid_o    = valid;
    assign bus.busy_o     = state != IDLE;
endmodule

// File: tb/tb_shift_add_mult.sv
// tb_shift_add_mult: directed self-checking bench for shift_add_mult (DataWidth=8, FracBits=4)
module tb_shift_add_mult;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    shift_add_mult_if #(.DataWidth(8)) bus ();

    shift_add_mult #(.DataWidth(8), .FracBits(4)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent reference: integer product, floor shift, saturate; returns {overflow, value}
    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
        int p;
        int s;
        p = int'($signed(a)) * int'($signed(b));
        s = p >>> 4;
        if (s > 127)  return {1'b1, 8'h7F};
        if (s < -128) return {1'b1, 8'h80};
        return {1'b0, 8'(s)};
    endfunction

    // Called at a negedge; the start is sampled at the following posedge (cycle 0)
    task automatic start_op(input logic [7:0] a, input logic [7:0] b);
        bus.start_i  = 1'b1;
        bus.mult_a_i = a;
        bus.mult_b_i = b;
        @(negedge clk);
        bus.start_i = 1'b0;
        check("done_low_after_start", bus.done_o, 0);
        check("valid_low_after_start", bus.valid_o, 0);
        check("busy_cycle1", bus.busy_o, 1);
    endtask

    // Entered in cycle 1; operands are scrambled to show they are not re-sampled
    task automatic wait_done(input int glitch, input logic [7:0] ev, input logic eo);
        int cyc    = 1;
        int busy_n = 0;
        while (!bus.done_o && cyc < 40) begin
            if (bus.busy_o) busy_n++;
            bus.start_i  = (cyc == glitch);
            bus.mult_a_i = 8'h7F;
            bus.mult_b_i = 8'h7F;
            @(negedge clk);
            cyc++;
        end
        bus.start_i = 1'b0;
        check("latency", cyc, 10);
        check("busy_cycles", busy_n, 9);
        check("busy_at_done", bus.busy_o, 0);
        check("value", bus.value_o, ev);
        check("overflow", bus.overflow_o, eo);
        check("valid", bus.valid_o, 1);
    endtask

    logic [7:0] va [9] = '{8'h18, 8'hE8, 8'h01, 8'h40, 8'h80, 8'h80, 8'h00, 8'hF0, 8'h7F};
    logic [7:0] vb [9] = '{8'h20, 8'h20, 8'hFF, 8'h40, 8'h40, 8'h80, 8'h85, 8'hF0, 8'h10};
    logic [7:0] vv [9] = '{8'h30, 8'hD0, 8'hFF, 8'h7F, 8'h80, 8'h7F, 8'h00, 8'h10, 8'h7F};
    logic       vo [9] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};

    initial begin
        logic       saw;
        logic [7:0] a, b;
        logic [8:0] r;
        rst          = 1'b1;
        bus.start_i  = 1'b0;
        bus.mult_a_i = '0;
        bus.mult_b_i = '0;
        repeat (2) @(negedge clk);
        check("rst_value", bus.value_o, 0);
        check("rst_overflow", bus.overflow_o, 0);
        check("rst_done", bus.done_o, 0);
        check("rst_valid", bus.valid_o, 0);
        check("rst_busy", bus.busy_o, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++) begin
            start_op(va[i], vb[i]);
            wait_done(0, vv[i], vo[i]);
            repeat (2) @(negedge clk);
            check("hold_done", bus.done_o, 0);
            check("hold_valid", bus.valid_o, 1);
            check("hold_value", bus.value_o, vv[i]);
        end

        // start during CALC is ignored, then back-to-back start in the done cycle
        start_op(8'h18, 8'h20);
        wait_done(4, 8'h30, 1'b0);
        start_op(8'hE8, 8'h20);
        wait_done(0, 8'hD0, 1'b0);
        start_op(8'h40, 8'h40);
        wait_done(0, 8'h7F, 1'b1);

        // reset mid-operation aborts with no done pulse
        @(negedge clk);
        start_op(8'h40, 8'h20);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_value", bus.value_o, 0);
        check("abort_overflow", bus.overflow_o, 0);
        check("abort_valid", bus.valid_o, 0);
        check("abort_busy", bus.busy_o, 0);
        saw = 1'b0;
        repeat (12) begin
            check("abort_done", bus.done_o, 0);
            saw |= bus.done_o;
            @(negedge clk);
        end
        check("abort_no_done_seen", saw, 0);
        start_op(8'h18, 8'h20);
        wait_done(0, 8'h30, 1'b0);

        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            r = model(a, b);
            @(negedge clk);
            start_op(a, b);
            wait_done(0, r[7:0], r[8]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/shift_add_mult.md
Name: shift_add_mult

Overview:
Shared sequential signed fixed-point multiplier. It is the responder on the operand/result interface that the multiplier port mux drives.
- Accepts one start pulse with two DataWidth operands.
- Runs a radix-2 shift-add over DataWidth cycles.
- Returns a rescaled, saturated DataWidth result with overflow, done and valid flags.
- One instance serves all neuron/accumulator requesters through the mux.

Parameters:
DataWidth, 8, operand and result width (two's complement), must be >= 2
FracBits, 4, fractional bits of operands/result (Q format), range 0..DataWidth-1

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  reset, synchronous, active-high
start_i  in  1  request; sampled only in IDLE
mult_a_i  in  DataWidth  operand A, signed
mult_b_i  in  DataWidth  operand B, signed
value_o  out  DataWidth  saturated signed result
overflow_o  out  1  result was saturated
done_o  out  1  one-cycle completion pulse
valid_o  out  1  value_o/overflow_o hold a completed result
busy_o  out  1  operation in progress (state != IDLE)

Behaviour:
- Reset (rst_i=1 at an edge, any state): state=IDLE; value_o=0, overflow_o=0, done_o=0, valid_o=0, busy_o=0; internal accumulator, count and operand registers cleared. Reset mid-operation aborts without any done_o.
- States: IDLE, CALC, FINISH.
- IDLE, start_i=1 at edge (cycle 0):
  - Latch |A| and |B| as DataWidth-bit unsigned magnitudes; -2^(DataWidth-1) maps to 2^(DataWidth-1).
  - Latch sign = A[msb] XOR B[msb]; clear the 2*DataWidth accumulator; count=0; valid_o<=0; go to CALC.
- CALC, each edge: if multiplier LSB=1, acc += multiplicand; multiplicand <<= 1; multiplier >>= 1; count++. After DataWidth iterations (cycles 1..DataWidth), go to FINISH.
- FINISH (cycle DataWidth+1), edge:
  - Form the signed product P = sign ? -acc : acc, as 2*DataWidth+1 bits.
  - S = P >>> FracBits (arithmetic shift, i.e. floor).
  - If S > 2^(DataWidth-1)-1: value_o = max positive, overflow_o=1.
  - If S < -2^(DataWidth-1): value_o = min negative, overflow_o=1.
  - Otherwise value_o = S[DataWidth-1:0], overflow_o=0.
  - done_o<=1, valid_o<=1; go to IDLE.
- Latency: done_o high exactly in cycle DataWidth+2 after the start cycle (cycle 10 for DataWidth=8); one cycle wide.
- valid_o, value_o and overflow_o hold until the next accepted start (valid_o drops at that edge) or reset.
- start_i while busy_o=1 (CALC/FINISH) is ignored; operands are not re-sampled.
- start_i in the cycle done_o=1 (state IDLE) is accepted: done_o falls, valid_o falls, new operation begins. Back-to-back throughput is one result per DataWidth+2 cycles.
- Zero operand: the full iteration count still runs (fixed latency); result 0, overflow_o=0.
- Inputs are treated as don't-care outside the start cycle.

Test Plan:
- DataWidth=8, FracBits=4: A=0x18 (1.5), B=0x20 (2.0), start 1 cycle -> done_o pulse at cycle 10, value_o=0x30, overflow_o=0, valid_o stays 1.
- A=0xE8 (-1.5), B=0x20 -> value_o=0xD0, overflow_o=0. A=0x01, B=0xFF -> value_o=0xFF (floor), overflow_o=0.
- A=0x40, B=0x40 -> value_o=0x7F, overflow_o=1. A=0x80, B=0x40 -> value_o=0x80, overflow_o=1. A=0x80, B=0x80 -> value_o=0x7F, overflow_o=1.
- Start A=0x18, B=0x20; pulse start_i with A=0x7F, B=0x7F at cycle 4 -> ignored; result 0x30 at cycle 10. New start in the done_o cycle -> accepted; valid_o low next cycle; next done_o 10 cycles later.
- Assert rst_i at cycle 5 of an operation -> all outputs 0, no done_o; start immediately after reset -> correct result with full latency.
- Random signed operands (10k) vs reference model (floor shift, saturate) for DataWidth=8/FracBits=4 and DataWidth=16/FracBits=0; also check done_o is single-cycle and busy_o is high from cycle 1 through cycle DataWidth+1.
